// File: rtl/dynamics_pkg.sv
// Shared types for the envelope generator: FSM state encoding and the quarter-step index helper.
package dynamics_pkg;

  localparam int QIDX_W = 16;

  // state | meaning: IDLE silent | ATTACK 0->peak | DECAY peak->sustain | SUSTAIN hold | RELEASE level->0
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ATTACK  = 3'd1,
    ST_DECAY   = 3'd2,
    ST_SUSTAIN = 3'd3,
    ST_RELEASE = 3'd4
  } env_state_t;

  localparam env_state_t ENV_RESET_STATE = ST_IDLE;

  function automatic logic [1:0] quarter_idx(input logic [QIDX_W-1:0] len,
                                             input logic [QIDX_W-1:0] cnt);
    logic [QIDX_W-1:0] t1, t2, t3;
    t1 = len >> 2;
    t2 = len >> 1;
    t3 = t1 + t2;
    return {1'b0, cnt >= t1} + {1'b0, cnt >= t2} + {1'b0, cnt >= t3};
  endfunction

endpackage

// File: rtl/envelope_ramp.sv
// Combinational quarter-step ramp: start moved toward target by (|target-start|*q)>>2 using shift/add only.
module envelope_ramp #(
  parameter int AMP_W = 8
) (
  input  logic [AMP_W-1:0] start,
  input  logic [AMP_W-1:0] target,
  input  logic [1:0]       q,
  output logic [AMP_W-1:0] level
);

  logic             rising;
  logic [AMP_W-1:0] span;
  logic [AMP_W+1:0] prod;
  logic [AMP_W-1:0] step;

  assign rising = (target >= start);
  assign span   = rising ? (target - start) : (start - target);
  assign prod   = (q[0] ? {2'b00, span} : '0) + (q[1] ? {1'b0, span, 1'b0} : '0);
  assign step   = AMP_W'(prod >> 2);
  assign level  = rising ? (start + step) : (start - step);

endmodule

// File: rtl/envelope_gen.sv
// ADSR envelope generator: FSM, beat counters, note latches and registered level output.
// ENVELOPE_FLOOR_EN floors the output to 1; the release length port is release_len since "release" is a keyword.
module envelope_gen
  import dynamics_pkg::*;
#(
  parameter int AMP_W = 8,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             beat,
  input  logic             new_note,
  input  logic             key_off,
  input  logic [AMP_W-1:0] amplitude_in,
  input  logic [AMP_W-1:0] sustain_in,
  input  logic [CNT_W-1:0] duration,
  input  logic [CNT_W-1:0] attack,
  input  logic [CNT_W-1:0] decay,
  input  logic [CNT_W-1:0] release_len,
  output logic [AMP_W-1:0] amplitude_out,
  output logic             busy,
  output logic             note_done
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  env_state_t       state, state_next;
  logic [CNT_W-1:0] note_cnt, phase_cnt;
  logic [CNT_W-1:0] dur_l, att_l, dec_l, rel_len_l, phase_len;
  logic [AMP_W-1:0] peak_l, sus_l, rel_l, level_r, level_next;
  logic [AMP_W-1:0] ramp_start, ramp_target, ramp_level;
  logic [1:0]       q;
  logic             rel_hit;

  // One extra bit so note_cnt + release cannot wrap below duration
  assign rel_hit = ({1'b0, note_cnt} + {1'b0, rel_len_l}) >= {1'b0, dur_l};

  always_comb begin
    state_next = state;
    if (new_note) begin
      state_next = ST_ATTACK;
    end else begin
      case (state)
        ST_IDLE:    state_next = ST_IDLE;
        ST_ATTACK:  if (key_off || rel_hit)          state_next = ST_RELEASE;
                    else if (phase_cnt >= att_l)     state_next = ST_DECAY;
        ST_DECAY:   if (key_off || rel_hit)          state_next = ST_RELEASE;
                    else if (phase_cnt >= dec_l)     state_next = ST_SUSTAIN;
        ST_SUSTAIN: if (key_off || rel_hit)          state_next = ST_RELEASE;
        ST_RELEASE: if (phase_cnt >= rel_len_l)      state_next = ST_IDLE;
        default:    state_next = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    ramp_start  = '0;
    ramp_target = '0;
    phase_len   = '0;
    case (state)
      ST_ATTACK:  begin ramp_target = peak_l; phase_len = att_l; end
      ST_DECAY:   begin ramp_start = peak_l; ramp_target = sus_l; phase_len = dec_l; end
      ST_RELEASE: begin ramp_start = rel_l; phase_len = rel_len_l; end
      default:    ;
    endcase
  end

  assign q = quarter_idx(QIDX_W'(phase_len), QIDX_W'(phase_cnt));

  envelope_ramp #(.AMP_W(AMP_W)) u_ramp (
    .start  (ramp_start),
    .target (ramp_target),
    .q      (q),
    .level  (ramp_level)
  );

  always_comb begin
    level_next = '0;
    case (state)
      ST_ATTACK, ST_DECAY, ST_RELEASE: level_next = ramp_level;
      ST_SUSTAIN:                      level_next = sus_l;
      default:                         level_next = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ENV_RESET_STATE;
      note_cnt  <= '0;
      phase_cnt <= '0;
      note_done <= 1'b0;
      level_r   <= '0;
    end else begin
      state     <= state_next;
      note_done <= (state == ST_RELEASE) && (state_next == ST_IDLE);
      level_r   <= level_next;
      if (new_note || state_next == ST_IDLE) begin
        note_cnt  <= '0;
        phase_cnt <= '0;
      end else begin
        if (beat && note_cnt != CNT_MAX) note_cnt <= note_cnt + 1'b1;
        if (state_next != state)                   phase_cnt <= '0;
        else if (beat && phase_cnt != CNT_MAX)     phase_cnt <= phase_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      peak_l    <= '0;
      sus_l     <= '0;
      rel_l     <= '0;
      dur_l     <= '0;
      att_l     <= '0;
      dec_l     <= '0;
      rel_len_l <= '0;
    end else begin
      if (new_note) begin
        peak_l    <= amplitude_in;
        sus_l     <= (sustain_in > amplitude_in) ? amplitude_in : sustain_in;
        dur_l     <= duration;
        att_l     <= attack;
        dec_l     <= decay;
        rel_len_l <= release_len;
      end
      // Release ramps down from whatever level was on the output when it began
      if (state_next == ST_RELEASE && state != ST_RELEASE) rel_l <= level_r;
    end
  end

`ifdef ENVELOPE_FLOOR_EN
  assign amplitude_out = (level_r == '0) ? AMP_W'(1) : level_r;
`else
  assign amplitude_out = level_r;
`endif

  assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_envelope_gen.sv
// Self-checking bench for envelope_gen: directed ADSR scenarios plus random traffic against a behavioural model.
module tb_envelope_gen;

  localparam int CMAX = 63;
`ifdef ENVELOPE_FLOOR_EN
  localparam bit FLOOR = 1'b1;
`else
  localparam bit FLOOR = 1'b0;
`endif
  localparam int FL = FLOOR ? 1 : 0;
  localparam int M_IDLE = 0, M_ATT = 1, M_DEC = 2, M_SUS = 3, M_REL = 4;

  logic       clk = 1'b0, reset_n = 1'b0, beat = 1'b0, new_note = 1'b0, key_off = 1'b0;
  logic [7:0] amplitude_in = '0, sustain_in = '0;
  logic [5:0] duration = '0, attack = '0, decay = '0, release_len = '0;
  logic [7:0] amplitude_out;
  logic       busy, note_done;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  envelope_gen #(.AMP_W(8), .CNT_W(6)) dut (
    .clk(clk), .reset_n(reset_n), .beat(beat), .new_note(new_note), .key_off(key_off),
    .amplitude_in(amplitude_in), .sustain_in(sustain_in), .duration(duration),
    .attack(attack), .decay(decay), .release_len(release_len),
    .amplitude_out(amplitude_out), .busy(busy), .note_done(note_done)
  );

  // Behavioural reference: phase name, beat counts and latched note, levels from plain arithmetic
  int m_ph, m_nc, m_pc, m_P, m_S, m_A, m_D, m_R, m_dur, m_rl, m_amp, m_lvl, m_nph;
  bit m_done;

  function automatic int qidx(int len, int c);
    int t1, t2;
    t1 = len / 4;
    t2 = len / 2;
    return int'(c >= t1) + int'(c >= t2) + int'(c >= t1 + t2);
  endfunction

  function automatic int ref_level();
    case (m_ph)
      M_ATT:   return (m_P * qidx(m_A, m_pc)) / 4;
      M_DEC:   return m_P - ((m_P - m_S) * qidx(m_D, m_pc)) / 4;
      M_SUS:   return m_S;
      M_REL:   return m_rl - (m_rl * qidx(m_R, m_pc)) / 4;
      default: return 0;
    endcase
  endfunction

  function automatic logic [7:0] exp_amp();
    return (FLOOR && m_amp == 0) ? 8'd1 : 8'(m_amp);
  endfunction

  initial begin
    m_ph = M_IDLE;
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) begin
        m_ph = M_IDLE; m_nc = 0; m_pc = 0; m_amp = 0; m_done = 0;
      end else begin
        m_lvl  = ref_level();
        m_nph  = m_ph;
        m_done = 0;
        if (new_note) begin
          m_P = int'(amplitude_in);
          m_S = (int'(sustain_in) > m_P) ? m_P : int'(sustain_in);
          m_A = int'(attack); m_D = int'(decay); m_R = int'(release_len); m_dur = int'(duration);
          m_nph = M_ATT; m_nc = 0; m_pc = 0;
        end else begin
          if (m_ph == M_ATT || m_ph == M_DEC || m_ph == M_SUS) begin
            if (key_off || (m_nc + m_R >= m_dur)) begin
              m_nph = M_REL;
              m_rl  = m_amp;
            end else if (m_ph == M_ATT && m_pc >= m_A) m_nph = M_DEC;
            else if (m_ph == M_DEC && m_pc >= m_D)     m_nph = M_SUS;
          end else if (m_ph == M_REL && m_pc >= m_R) begin
            m_nph  = M_IDLE;
            m_done = 1;
          end
          if (m_nph == M_IDLE) begin
            m_nc = 0; m_pc = 0;
          end else begin
            if (beat) m_nc = (m_nc < CMAX) ? m_nc + 1 : CMAX;
            if (m_nph != m_ph) m_pc = 0;
            else if (beat)     m_pc = (m_pc < CMAX) ? m_pc + 1 : CMAX;
          end
        end
        m_ph  = m_nph;
        m_amp = m_lvl;
      end
    end
  end

  task automatic set_note(input int p, input int s, input int a, input int d, input int r, input int dur);
    amplitude_in = 8'(p); sustain_in = 8'(s);
    attack = 6'(a); decay = 6'(d); release_len = 6'(r); duration = 6'(dur);
  endtask

  task automatic idle_inputs();
    new_note = 1'b0; key_off = 1'b0; beat = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    idle_inputs();
    repeat (2) @(negedge clk);
    checks += 3;
    if (amplitude_out !== 8'(FL)) begin errors++; $display("FAIL reset.amp got=%0d exp=%0d", amplitude_out, FL); end
    if (busy !== 1'b0)            begin errors++; $display("FAIL reset.busy got=%0b exp=0", busy); end
    if (note_done !== 1'b0)       begin errors++; $display("FAIL reset.done got=%0b exp=0", note_done); end
    reset_n = 1'b1;
  endtask

  task automatic test_full_note();
    int seq[$];
    int exp_seq[13] = '{0, 50, 100, 150, 200, 175, 150, 125, 100, 75, 50, 25, 0};
    int last = -1;
    int dones = 0;
    exp_seq[0] = FL; exp_seq[12] = FL;
    set_note(200, 100, 8, 4, 8, 40);
    for (int i = 0; i < 240; i++) begin
      @(negedge clk);
      checks += 3;
      if (amplitude_out !== exp_amp()) begin errors++; $display("FAIL full_note.amp i=%0d got=%0d exp=%0d", i, amplitude_out, exp_amp()); end
      if (busy !== (m_ph != M_IDLE))   begin errors++; $display("FAIL full_note.busy i=%0d got=%0b exp=%0b", i, busy, m_ph != M_IDLE); end
      if (note_done !== m_done)        begin errors++; $display("FAIL full_note.done i=%0d got=%0b exp=%0b", i, note_done, m_done); end
      if (int'(amplitude_out) != last) begin seq.push_back(int'(amplitude_out)); last = int'(amplitude_out); end
      if (note_done === 1'b1) dones++;
      new_note = (i == 0); key_off = 1'b0; beat = (i > 0 && i % 4 == 0);
    end
    idle_inputs();
    checks += 2;
    if (seq.size() != 13) begin errors++; $display("FAIL full_note.levels count got=%0d exp=13", seq.size()); end
    else for (int k = 0; k < 13; k++)
      if (seq[k] != exp_seq[k]) begin errors++; $display("FAIL full_note.level[%0d] got=%0d exp=%0d", k, seq[k], exp_seq[k]); end
    if (dones != 1) begin errors++; $display("FAIL full_note.done_pulses got=%0d exp=1", dones); end
  endtask

  task automatic test_key_off();
    int seq[$];
    int exp_seq[6] = '{0, 50, 38, 25, 13, 0};
    int last = -1;
    int dones = 0;
    exp_seq[0] = FL; exp_seq[5] = FL;
    set_note(200, 100, 16, 4, 4, 63);
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      checks += 3;
      if (amplitude_out !== exp_amp()) begin errors++; $display("FAIL key_off.amp i=%0d got=%0d exp=%0d", i, amplitude_out, exp_amp()); end
      if (busy !== (m_ph != M_IDLE))   begin errors++; $display("FAIL key_off.busy i=%0d got=%0b exp=%0b", i, busy, m_ph != M_IDLE); end
      if (note_done !== m_done)        begin errors++; $display("FAIL key_off.done i=%0d got=%0b exp=%0b", i, note_done, m_done); end
      if (int'(amplitude_out) != last) begin seq.push_back(int'(amplitude_out)); last = int'(amplitude_out); end
      if (note_done === 1'b1) dones++;
      new_note = (i == 0); key_off = (i == 23); beat = (i > 0 && i % 4 == 0);
    end
    idle_inputs();
    checks += 2;
    if (seq.size() != 6) begin errors++; $display("FAIL key_off.levels count got=%0d exp=6", seq.size()); end
    else for (int k = 0; k < 6; k++)
      if (seq[k] != exp_seq[k]) begin errors++; $display("FAIL key_off.level[%0d] got=%0d exp=%0d", k, seq[k], exp_seq[k]); end
    if (dones != 1) begin errors++; $display("FAIL key_off.done_pulses got=%0d exp=1", dones); end
  endtask

  task automatic test_retrigger();
    int early_dones = 0;
    int dones = 0;
    set_note(200, 100, 4, 4, 4, 60);
    for (int i = 0; i < 90; i++) begin
      @(negedge clk);
      checks += 3;
      if (amplitude_out !== exp_amp()) begin errors++; $display("FAIL retrigger.amp i=%0d got=%0d exp=%0d", i, amplitude_out, exp_amp()); end
      if (busy !== (m_ph != M_IDLE))   begin errors++; $display("FAIL retrigger.busy i=%0d got=%0b exp=%0b", i, busy, m_ph != M_IDLE); end
      if (note_done !== m_done)        begin errors++; $display("FAIL retrigger.done i=%0d got=%0b exp=%0b", i, note_done, m_done); end
      if (i == 39) begin
        checks++;
        if (amplitude_out !== 8'd100) begin errors++; $display("FAIL retrigger.sustain_level got=%0d exp=100", amplitude_out); end
      end
      if (i == 41) begin
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL retrigger.busy_t1 got=%0b exp=1", busy); end
      end
      if (i == 42) begin
        checks++;
        if (amplitude_out !== 8'(FL)) begin errors++; $display("FAIL retrigger.level_t2 got=%0d exp=%0d", amplitude_out, FL); end
      end
      if (note_done === 1'b1) begin dones++; if (i <= 50) early_dones++; end
      if (i == 40) set_note(120, 90, 4, 4, 4, 12);
      new_note = (i == 0 || i == 40); key_off = 1'b0; beat = (i > 0 && i % 2 == 0);
    end
    idle_inputs();
    checks += 2;
    if (early_dones != 0) begin errors++; $display("FAIL retrigger.no_done got=%0d exp=0", early_dones); end
    if (dones != 1)       begin errors++; $display("FAIL retrigger.done_pulses got=%0d exp=1", dones); end
  endtask

  task automatic test_zero_len();
    int dones = 0;
    set_note(200, 100, 0, 0, 0, 10);
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      checks += 3;
      if (amplitude_out !== exp_amp()) begin errors++; $display("FAIL zero_len.amp i=%0d got=%0d exp=%0d", i, amplitude_out, exp_amp()); end
      if (busy !== (m_ph != M_IDLE))   begin errors++; $display("FAIL zero_len.busy i=%0d got=%0b exp=%0b", i, busy, m_ph != M_IDLE); end
      if (note_done !== m_done)        begin errors++; $display("FAIL zero_len.done i=%0d got=%0b exp=%0b", i, note_done, m_done); end
      if (note_done === 1'b1) dones++;
      new_note = (i == 0); key_off = 1'b0; beat = (i > 0 && i % 3 == 0);
    end
    idle_inputs();
    checks += 2;
    if (dones != 1)    begin errors++; $display("FAIL zero_len.done_pulses got=%0d exp=1", dones); end
    if (busy !== 1'b0) begin errors++; $display("FAIL zero_len.idle_end got=%0b exp=0", busy); end
  endtask

  task automatic test_simultaneous();
    set_note(200, 100, 4, 4, 4, 60);
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      checks += 3;
      if (amplitude_out !== exp_amp()) begin errors++; $display("FAIL simul.amp i=%0d got=%0d exp=%0d", i, amplitude_out, exp_amp()); end
      if (busy !== (m_ph != M_IDLE))   begin errors++; $display("FAIL simul.busy i=%0d got=%0b exp=%0b", i, busy, m_ph != M_IDLE); end
      if (note_done !== m_done)        begin errors++; $display("FAIL simul.done i=%0d got=%0b exp=%0b", i, note_done, m_done); end
      if (i == 42) begin
        checks++;
        if (amplitude_out !== 8'(FL)) begin errors++; $display("FAIL simul.attack_q0 got=%0d exp=%0d", amplitude_out, FL); end
      end
      if (i == 59) begin
        checks++;
        if (amplitude_out !== 8'd200) begin errors++; $display("FAIL simul.decay_q0 got=%0d exp=200", amplitude_out); end
      end
      new_note = (i == 0 || i == 40); key_off = (i == 40);
      beat = (i > 0 && i % 4 == 0) || (i == 57);
    end
    // Finish the note with a key-off so the next test starts idle
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      new_note = 1'b0; key_off = (i == 0); beat = (i % 2 == 0);
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    int dones = 0;
    set_note(200, 100, 8, 4, 8, 40);
    for (int i = 0; i < 22; i++) begin
      @(negedge clk);
      checks += 3;
      if (amplitude_out !== exp_amp()) begin errors++; $display("FAIL reset_mid.amp i=%0d got=%0d exp=%0d", i, amplitude_out, exp_amp()); end
      if (busy !== (m_ph != M_IDLE))   begin errors++; $display("FAIL reset_mid.busy i=%0d got=%0b exp=%0b", i, busy, m_ph != M_IDLE); end
      if (note_done !== m_done)        begin errors++; $display("FAIL reset_mid.done i=%0d got=%0b exp=%0b", i, note_done, m_done); end
      new_note = (i == 0); key_off = 1'b0; beat = (i > 0 && i % 2 == 0);
    end
    #2 reset_n = 1'b0;
    #1;
    checks += 3;
    if (amplitude_out !== 8'(FL)) begin errors++; $display("FAIL reset_mid.async_amp got=%0d exp=%0d", amplitude_out, FL); end
    if (busy !== 1'b0)            begin errors++; $display("FAIL reset_mid.async_busy got=%0b exp=0", busy); end
    if (note_done !== 1'b0)       begin errors++; $display("FAIL reset_mid.async_done got=%0b exp=0", note_done); end
    idle_inputs();
    @(negedge clk);
    reset_n = 1'b1;
    set_note(100, 60, 2, 2, 2, 8);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      checks += 3;
      if (amplitude_out !== exp_amp()) begin errors++; $display("FAIL reset_mid.clean_amp i=%0d got=%0d exp=%0d", i, amplitude_out, exp_amp()); end
      if (busy !== (m_ph != M_IDLE))   begin errors++; $display("FAIL reset_mid.clean_busy i=%0d got=%0b exp=%0b", i, busy, m_ph != M_IDLE); end
      if (note_done !== m_done)        begin errors++; $display("FAIL reset_mid.clean_done i=%0d got=%0b exp=%0b", i, note_done, m_done); end
      if (note_done === 1'b1) dones++;
      new_note = (i == 0); key_off = 1'b0; beat = (i > 0 && i % 2 == 0);
    end
    idle_inputs();
    checks++;
    if (dones != 1) begin errors++; $display("FAIL reset_mid.clean_done_pulses got=%0d exp=1", dones); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      checks += 3;
      if (amplitude_out !== exp_amp()) begin errors++; $display("FAIL random.amp i=%0d got=%0d exp=%0d", i, amplitude_out, exp_amp()); end
      if (busy !== (m_ph != M_IDLE))   begin errors++; $display("FAIL random.busy i=%0d got=%0b exp=%0b", i, busy, m_ph != M_IDLE); end
      if (note_done !== m_done)        begin errors++; $display("FAIL random.done i=%0d got=%0b exp=%0b", i, note_done, m_done); end
      amplitude_in = 8'($urandom);
      sustain_in   = 8'($urandom);
      attack       = 6'($urandom_range(15));
      decay        = 6'($urandom_range(15));
      release_len  = 6'($urandom_range(15));
      duration     = 6'($urandom_range(63));
      new_note = (m_ph == M_IDLE) ? ($urandom_range(24) == 0) : ($urandom_range(199) == 0);
      key_off  = ($urandom_range(119) == 0);
      beat     = ($urandom_range(2) == 0);
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_full_note();
    test_key_off();
    test_retrigger();
    test_zero_len();
    test_simultaneous();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
